// File: rtl/decode_queue_pkg.sv
// Shared types for the decode stage: IFD/IX interface structs, RV32IM opcode
// constants and the decoded-entry record buffered by decode_queue.
`default_nettype none

package decode_queue_pkg;

    localparam int DQ_XLEN          = 32;
    localparam int DQ_DEPTH_DEFAULT = 4;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam int         EXE_PIPE_W       = 4;
    localparam logic [3:0] EXE_PIPE_INVALID = 4'b0000;
    localparam logic [3:0] EXE_PIPE_ALU     = 4'b0001;
    localparam logic [3:0] EXE_PIPE_MUL     = 4'b0010;
    localparam logic [3:0] EXE_PIPE_DIV     = 4'b0100;
    localparam logic [3:0] EXE_PIPE_LSU     = 4'b1000;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SH
    } imm_type_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU
    } mul_op_e;

    typedef enum logic [1:0] {
        DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU
    } div_op_e;

    typedef struct packed {
        logic [31:0]        instr;
        logic [DQ_XLEN-1:0] pc;
        logic [DQ_XLEN-1:0] pc_inc;
    } ifd_id_inf_t;

    typedef struct packed {
        logic [DQ_XLEN-1:0]    pc;
        logic [DQ_XLEN-1:0]    pc_inc;
        logic [4:0]            rd;
        logic [4:0]            a1;
        logic [4:0]            a2;
        logic [DQ_XLEN-1:0]    imm_ext;
        imm_type_e             imm_type;
        alu_op_e               alu_op;
        mul_op_e               mul_op;
        div_op_e               div_op;
        logic [EXE_PIPE_W-1:0] exe_pipe;
        logic [2:0]            funct3;
        logic                  alu_src;
        logic                  alu_a_pc;
        logic                  register_write;
        logic                  mem_load;
        logic                  mem_store;
        logic                  branch;
        logic                  jump;
        logic                  icache_invalidate;
    } id_ix_inf_t;

    typedef struct packed {
        id_ix_inf_t inf;
        logic       illegal;
    } id_entry_t;

    // alt selects SUB/SRA; only meaningful for funct3 000 and 101.
    function automatic alu_op_e alu_op_from(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_queue_instr_decoder.sv
// Combinational RV32IM decoder: one fetched instruction in, one decoded
// queue entry (with illegal-opcode flag) out.
`default_nettype none

module instr_decoder
    import decode_queue_pkg::*;
#(
    parameter int XLEN = DQ_XLEN
) (
    input  ifd_id_inf_t ifd_id_inf,
    output id_entry_t   entry
);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm;

    assign instr  = ifd_id_inf.instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        entry                = '0;
        imm_type             = IMM_I;
        imm                  = '0;
        entry.inf.pc         = ifd_id_inf.pc;
        entry.inf.pc_inc     = ifd_id_inf.pc_inc;
        entry.inf.rd         = instr[11:7];
        entry.inf.a1         = instr[19:15];
        entry.inf.a2         = instr[24:20];
        entry.inf.funct3     = funct3;
        entry.inf.alu_op     = ALU_ADD;
        entry.inf.exe_pipe   = EXE_PIPE_ALU;

        case (opcode)
            OPC_R_TYPE: begin
                entry.inf.register_write = 1'b1;
                if (funct7 == FUNCT7_MULDIV) begin
                    entry.inf.exe_pipe = funct3[2] ? EXE_PIPE_DIV : EXE_PIPE_MUL;
                    entry.inf.mul_op   = mul_op_e'(funct3[1:0]);
                    entry.inf.div_op   = div_op_e'(funct3[1:0]);
                end else if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
                    entry.inf.alu_op = alu_op_from(funct3, funct7[5]);
                end else begin
                    entry.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                entry.inf.exe_pipe       = EXE_PIPE_LSU;
                entry.inf.a2             = '0;
                entry.inf.alu_src        = 1'b1;
                entry.inf.mem_load       = 1'b1;
                entry.inf.register_write = 1'b1;
            end
            OPC_STORE: begin
                imm_type              = IMM_S;
                entry.inf.exe_pipe    = EXE_PIPE_LSU;
                entry.inf.rd          = '0;
                entry.inf.alu_src     = 1'b1;
                entry.inf.mem_store   = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type          = IMM_B;
                entry.inf.rd      = '0;
                entry.inf.branch  = 1'b1;
                entry.inf.alu_op  = ALU_SUB;
            end
            OPC_I_TYPE: begin
                // Shift-immediates carry a 5-bit shamt; instr[30] only matters for SRAI.
                imm_type                 = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
                entry.inf.a2             = '0;
                entry.inf.alu_src        = 1'b1;
                entry.inf.register_write = 1'b1;
                entry.inf.alu_op         = alu_op_from(funct3, (funct3 == 3'b101) && instr[30]);
            end
            OPC_JAL: begin
                imm_type                 = IMM_J;
                entry.inf.a1             = '0;
                entry.inf.a2             = '0;
                entry.inf.alu_src        = 1'b1;
                entry.inf.alu_a_pc       = 1'b1;
                entry.inf.jump           = 1'b1;
                entry.inf.register_write = 1'b1;
            end
            OPC_JALR: begin
                entry.inf.a2             = '0;
                entry.inf.alu_src        = 1'b1;
                entry.inf.jump           = 1'b1;
                entry.inf.register_write = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type                 = IMM_U;
                entry.inf.a1             = '0;
                entry.inf.a2             = '0;
                entry.inf.alu_src        = 1'b1;
                entry.inf.alu_a_pc       = (opcode == OPC_AUIPC);
                entry.inf.register_write = 1'b1;
            end
            OPC_FENCE: begin
                entry.inf.rd                = '0;
                entry.inf.icache_invalidate = (funct3 == 3'b001);
            end
            default: entry.illegal = 1'b1;
        endcase

        if (entry.illegal) begin
            entry.inf.exe_pipe  = EXE_PIPE_INVALID;
            entry.inf.mem_load  = 1'b0;
            entry.inf.mem_store = 1'b0;
        end
        if (entry.illegal || entry.inf.rd == 5'd0) begin
            entry.inf.register_write = 1'b0;
        end

        case (imm_type)
            IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_SH:  imm = XLEN'(instr[24:20]);
            default: imm = XLEN'($signed(instr[31:20]));
        endcase
        entry.inf.imm_type = imm_type;
        entry.inf.imm_ext  = imm;
    end

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry FIFO toward IX: decodes on push, valid/ready
// on both sides, whole-queue flush on a WB branch.
`default_nettype none

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH_DEFAULT,
    parameter int XLEN  = DQ_XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_do_branch,
    input  logic                       ifd_valid,
    output logic                       ifd_ready,
    input  ifd_id_inf_t                ifd_id_inf,
    output logic                       id_valid,
    input  logic                       ix_ready,
    output id_ix_inf_t                 id_ix_inf,
    output logic                       id_illegal,
    output logic [$clog2(DEPTH+1)-1:0] id_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    id_entry_t        mem [DEPTH];
    id_entry_t        dec_entry;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    instr_decoder #(
        .XLEN (XLEN)
    ) u_instr_decoder (
        .ifd_id_inf (ifd_id_inf),
        .entry      (dec_entry)
    );

    // Readiness depends only on occupancy, never on ix_ready, so IX stalls
    // cannot ripple combinationally back into IFD.
    assign ifd_ready  = rst_n && (count != CNT_W'(DEPTH));
    assign id_valid   = (count != '0);
    assign push       = ifd_valid && ifd_ready;
    assign pop        = id_valid && ix_ready;
    assign id_count   = count;
    assign id_ix_inf  = mem[rd_ptr].inf;
    assign id_illegal = id_valid && mem[rd_ptr].illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (wb_do_branch) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !wb_do_branch) begin
            mem[wr_ptr] <= dec_entry;
        end
    end

endmodule

`default_nettype wire
